// File: rtl/mrd_tag_pool_if.sv
// Channel-facing signals of the shared MRd tag pool: request/grant, tag release and owner query.
interface mrd_tag_pool_if #(
  parameter int NUM_CHANS = 4,
  parameter int CHAN_W    = (NUM_CHANS > 1) ? $clog2(NUM_CHANS) : 1
);
  logic [NUM_CHANS-1:0] alloc_tag_req;
  logic [NUM_CHANS-1:0] allocated_tag_rdy;
  logic [7:0]           allocated_tag;
  logic                 tag_release_valid;
  logic [7:0]           tag_release_tag;
  logic [7:0]           owner_query_tag;
  logic [CHAN_W-1:0]    owner_chan;
  logic                 owner_valid;

  modport master (
    output alloc_tag_req, tag_release_valid, tag_release_tag, owner_query_tag,
    input  allocated_tag_rdy, allocated_tag, owner_chan, owner_valid
  );

  modport slave (
    input  alloc_tag_req, tag_release_valid, tag_release_tag, owner_query_tag,
    output allocated_tag_rdy, allocated_tag, owner_chan, owner_valid
  );
endinterface

// File: rtl/mrd_tag_pool.sv
// Shared non-posted tag allocator: free-list FIFO, round-robin grant, in-use bitmap and
// owner table so completions can be steered back to the requesting channel.
module mrd_tag_pool #(
  parameter int NUM_CHANS = 4,
  parameter int NUM_TAGS  = 32,
  parameter int CHAN_W    = (NUM_CHANS > 1) ? $clog2(NUM_CHANS) : 1
) (
  input  logic              s_axi_clk,
  input  logic              s_axi_rstn,
  mrd_tag_pool_if.slave     tp,
  output logic [8:0]        free_count,
  output logic              init_done,
  output logic              release_err
);
  localparam int TAG_W = $clog2(NUM_TAGS);
  localparam int unsigned NC = NUM_CHANS;

  typedef enum logic {INIT, RUN} state_t;
  state_t state, state_nxt;

  logic [TAG_W-1:0]     fifo [NUM_TAGS];
  logic [CHAN_W-1:0]    owner [NUM_TAGS];
  logic [TAG_W-1:0]     rd_ptr, wr_ptr;
  logic [8:0]           count;
  logic [NUM_TAGS-1:0]  in_use;
  logic [CHAN_W-1:0]    rr_ptr;
  logic [NUM_CHANS-1:0] rdy;
  logic [7:0]           tag_q;
  logic [CHAN_W-1:0]    owner_chan_q;
  logic                 owner_valid_q;

  logic [NUM_CHANS-1:0] eligible;
  logic [NUM_CHANS-1:0] gnt;
  logic                 win_found;
  logic [CHAN_W-1:0]    win_idx;
  int unsigned          idx;
  logic [TAG_W-1:0]     head, rel_tag, qry_tag;
  logic                 rel_in_range, qry_in_range, rel_ok, rel_bad, push, pop;

  always_ff @(posedge s_axi_clk) begin
    if (!s_axi_rstn) state <= INIT;
    else             state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      INIT:    if (wr_ptr == TAG_W'(NUM_TAGS - 1)) state_nxt = RUN;
      RUN:     state_nxt = RUN;
      default: state_nxt = INIT;
    endcase
  end

  // The previous grantee is still holding req while its rdy pulse is out; mask it.
  assign eligible = tp.alloc_tag_req & ~rdy;

  always_comb begin
    win_found = 1'b0;
    win_idx   = '0;
    idx       = 0;
    gnt       = '0;
    for (int unsigned i = 1; i <= NC; i++) begin
      idx = 32'(rr_ptr) + i;
      if (idx >= NC) idx = idx - NC;
      if (!win_found && eligible[idx[CHAN_W-1:0]]) begin
        win_found = 1'b1;
        win_idx   = CHAN_W'(idx);
      end
    end
    gnt[win_idx] = win_found;
  end

  assign head         = fifo[rd_ptr];
  assign rel_tag      = tp.tag_release_tag[TAG_W-1:0];
  assign qry_tag      = tp.owner_query_tag[TAG_W-1:0];
  assign rel_in_range = {1'b0, tp.tag_release_tag} < 9'(NUM_TAGS);
  assign qry_in_range = {1'b0, tp.owner_query_tag} < 9'(NUM_TAGS);
  assign rel_ok       = (state == RUN) && tp.tag_release_valid && rel_in_range && in_use[rel_tag];
  assign rel_bad      = (state == RUN) && tp.tag_release_valid && !(rel_in_range && in_use[rel_tag]);
  assign push         = (state == INIT) || rel_ok;
  // Pop decision uses the registered count, so a tag released this cycle waits one cycle.
  assign pop          = (state == RUN) && (count != '0) && win_found;

  always_ff @(posedge s_axi_clk) begin
    if (!s_axi_rstn) begin
      rd_ptr        <= '0;
      wr_ptr        <= '0;
      count         <= '0;
      in_use        <= '0;
      rr_ptr        <= CHAN_W'(NUM_CHANS - 1);
      rdy           <= '0;
      tag_q         <= '0;
      owner_chan_q  <= '0;
      owner_valid_q <= 1'b0;
      release_err   <= 1'b0;
    end else begin
      rdy <= '0;
      if (state == INIT) begin
        fifo[wr_ptr] <= wr_ptr;
        wr_ptr       <= wr_ptr + 1'b1;
      end else if (rel_ok) begin
        fifo[wr_ptr]    <= rel_tag;
        wr_ptr          <= wr_ptr + 1'b1;
        in_use[rel_tag] <= 1'b0;
      end
      if (pop) begin
        rdy          <= gnt;
        tag_q        <= 8'(head);
        rd_ptr       <= rd_ptr + 1'b1;
        in_use[head] <= 1'b1;
        owner[head]  <= win_idx;
        rr_ptr       <= win_idx;
      end
      if (rel_bad) release_err <= 1'b1;
      count         <= count + {8'd0, push} - {8'd0, pop};
      owner_chan_q  <= owner[qry_tag];
      owner_valid_q <= qry_in_range && in_use[qry_tag];
    end
  end

  assign tp.allocated_tag_rdy = rdy;
  assign tp.allocated_tag     = tag_q;
  assign tp.owner_chan        = owner_chan_q;
  assign tp.owner_valid       = owner_valid_q;
  assign free_count           = count;
  assign init_done            = (state == RUN);
endmodule

// File: doc/mrd_tag_pool.md
# mrd_tag_pool

Shared PCIe read-request tag allocator that feeds the `alloc_tag_req` / `allocated_tag_rdy` / `allocated_tag` interface of every S2C DMA channel's MRd requestor.
- Holds a free list of non-posted tags and grants one tag per cycle to the requesting channels in round-robin order.
- Returns a tag to the pool when the completion path reports the final completion for that tag.
- Records the owning channel of each outstanding tag so completions can be routed back to it.

## Interface
Parameters:
- NUM_CHANS, 4, number of requesting DMA channels (1..16)
- NUM_TAGS, 32, number of tags in the pool (2..256, power of 2); tag values are 0..NUM_TAGS-1
- CHAN_W, clog2(NUM_CHANS) with a minimum of 1, width of a channel index

Ports (one clock; reset is synchronous and active-low):
- s_axi_clk  in  1  clock for all logic
- s_axi_rstn  in  1  synchronous active-low reset
- alloc_tag_req  in  NUM_CHANS  per-channel level request, held until that channel's rdy pulse
- allocated_tag_rdy  out  NUM_CHANS  one-hot, one-cycle grant pulse
- allocated_tag  out  8  granted tag, valid while any allocated_tag_rdy bit is high; upper bits zero
- tag_release_valid  in  1  completion path has received the last completion for tag_release_tag
- tag_release_tag  in  8  tag being returned
- owner_query_tag  in  8  tag of the incoming completion
- owner_chan  out  CHAN_W  owner of owner_query_tag, one cycle later
- owner_valid  out  1  the queried tag was in use, one cycle later
- free_count  out  9  number of tags currently in the free list
- init_done  out  1  free list is populated and grants are enabled
- release_err  out  1  sticky: release of a tag that was not in use

## Operation
- States are INIT and RUN. Reset enters INIT.
- INIT:
  - Writes tags 0..NUM_TAGS-1 into the free-list FIFO, one per cycle.
  - No grants are issued and releases are ignored.
  - After the last write the block enters RUN and asserts init_done.
- Free list: a FIFO of depth NUM_TAGS with registered read and write pointers and a count.
- In-use bitmap: NUM_TAGS bits. Owner table: NUM_TAGS × CHAN_W registers.
- Grant, one per cycle at most, in RUN when free_count > 0:
  - Arbitration is round-robin over req & ~lockout, searching upward from the channel after the last grantee.
  - The winner receives a registered rdy pulse together with the FIFO head tag.
  - That tag's in-use bit is set and its owner entry is written.
  - The winner is locked out for the cycle after its pulse, so the still-high req is not granted twice. The requestor drops req the cycle after rdy.
- Release:
  - If tag_release_valid is high and the tag is in use: the tag is pushed to the FIFO tail and its in-use bit is cleared.
  - If the tag is not in use, or is ≥ NUM_TAGS: no push, and release_err is set until reset.
- Simultaneous grant and release:
  - Both proceed in the same cycle and free_count is unchanged.
  - A tag released in cycle N can be granted no earlier than cycle N+1.
  - With the FIFO empty, a release at N allows a grant whose pulse appears at N+2.
- Owner query:
  - owner_chan and owner_valid are registered from the table and bitmap.
  - If a query and a release of the same tag occur in the same cycle, owner_valid=1 (pre-release state).
- free_count arithmetic: count + push − pop. It never exceeds NUM_TAGS and never underflows, because a pop only occurs when count > 0.
- Reset mid-operation:
  - All outstanding tags are forgotten: bitmap cleared, FIFO re-initialised via INIT.
  - Requestors are reset by the same reset.

## Timing
- Reset values:
  - Outputs: allocated_tag_rdy=0, allocated_tag=0, owner_chan=0, owner_valid=0, free_count=0, init_done=0, release_err=0.
  - Round-robin pointer: NUM_CHANS−1, so channel 0 has first priority.
- free_count increments during INIT, reaching NUM_TAGS in the same cycle init_done rises, i.e. NUM_TAGS cycles after reset deasserts.
- Grant latency: a request sampled high at edge N with a tag free produces rdy and tag during cycle N+1.
- Sustained throughput is one grant per cycle across channels. A single channel gets at most one grant per two cycles.
- Release-to-free_count latency: 1 cycle. Query-to-owner latency: 1 cycle.

## Test plan
- Reset, then idle: init_done rises after exactly 32 cycles, free_count=32, no rdy pulses.
- Channels 0–3 all requesting continuously, no releases:
  - Grants go to channels 0,1,2,3,0,… with tags 0,1,2,…,31.
  - free_count reaches 0 and further requests stall with no rdy.
- Pool empty, channel 2 requesting, release tag 17 at cycle N: channel 2 gets rdy with tag 17 at N+2, and owner query of 17 returns chan 2, valid.
- Release tag 5 while it is free: release_err=1, free_count unchanged, and the next grant does not return 5 twice.
- Grant and release in the same cycle with free_count=10: free_count stays 10, and the released tag is queued at the FIFO tail.
- Assert reset with 20 tags outstanding: after reset, INIT repeats, free_count=32 and release_err=0.
